// File: rtl/md_ctrl_pipe_if.sv
// D-stage instruction/flush inputs and E-stage control outputs of md_ctrl_pipe.
// master drives the instruction side; slave is the decoder/ID-EX block.
interface md_ctrl_pipe_if;
  logic [31:0] InstrD;
  logic        FlushE;
  logic [2:0]  ImmSrcD;
  logic        IllegalD;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        BranchE;
  logic        JumpE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic        MdStall;
  logic        MdDoneE;

  modport master (
    output InstrD, FlushE,
    input  ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           ResultSrcE, ALUControlE, MdStall, MdDoneE
  );

  modport slave (
    input  InstrD, FlushE,
    output ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           ResultSrcE, ALUControlE, MdStall, MdDoneE
  );
endinterface

// File: rtl/md_ctrl_pipe.sv
// RV32I decoder with ID/EX control register: ImmSrcD/IllegalD combinational, *E outputs one cycle later.
// MD_CTRL_MEXT_EN adds mul/div/rem decode plus a countdown FSM that holds E and stalls F/D for L-1 cycles.
module md_ctrl_pipe #(
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  md_ctrl_pipe_if.slave bus
);

  localparam int CW = $clog2(32 + 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_REM  = 4'b1011;
  localparam logic [3:0] ALU_SLTU = 4'b1100;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [3:0] alu_ctrl;
  } ctrl_t;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  ctrl_t      dec;
  logic [2:0] imm_src;
  logic       illegal;
  ctrl_t      ctrl_e_d, ctrl_e_q;
  logic       md_stall;
  logic       md_done;
  logic       unused_cfg;

  assign opcode = bus.InstrD[6:0];
  assign funct3 = bus.InstrD[14:12];
  assign funct7 = bus.InstrD[31:25];
  assign unused_cfg = ^{bus.InstrD[24:7], MUL_LATENCY[0], DIV_LATENCY[0]};

  // funct3 mapping shared by R-type (funct7 0) and I-ALU
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec     = '0;
    imm_src = 3'b000;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        illegal        = (funct3 != 3'b010);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src       = 3'b001;
        illegal       = (funct3 != 3'b010);
      end
      OP_R: begin
        dec.reg_write = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_ctrl = base_alu(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) dec.alu_ctrl = ALU_SRA;
            else                       illegal = 1'b1;
          end
`ifdef MD_CTRL_MEXT_EN
          7'b0000001: begin
            case (funct3)
              3'b000:  dec.alu_ctrl = ALU_MUL;
              3'b100:  dec.alu_ctrl = ALU_DIV;
              3'b110:  dec.alu_ctrl = ALU_REM;
              default: illegal = 1'b1;
            endcase
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = base_alu(funct3);
        // shift-immediates carry funct7 in imm[11:5]; only srai may set bit 30
        if (funct3 == 3'b001 && funct7 != 7'b0000000) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000)      dec.alu_ctrl = ALU_SRA;
          else if (funct7 != 7'b0000000) illegal = 1'b1;
        end
      end
      OP_BR: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        imm_src      = 3'b010;
        illegal      = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        imm_src        = 3'b011;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_src       = 3'b100;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec     = '0;
      imm_src = 3'b000;
    end
  end

  assign bus.ImmSrcD  = imm_src;
  assign bus.IllegalD = illegal;

  always_comb begin
    ctrl_e_d = ctrl_e_q;
    if (bus.FlushE)     ctrl_e_d = '0;
    else if (!md_stall) ctrl_e_d = dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_e_q <= '0;
    else        ctrl_e_q <= ctrl_e_d;
  end

  assign bus.RegWriteE   = ctrl_e_q.reg_write;
  assign bus.MemWriteE   = ctrl_e_q.mem_write;
  assign bus.ALUSrcE     = ctrl_e_q.alu_src;
  assign bus.BranchE     = ctrl_e_q.branch;
  assign bus.JumpE       = ctrl_e_q.jump;
  assign bus.ResultSrcE  = ctrl_e_q.result_src;
  assign bus.ALUControlE = ctrl_e_q.alu_ctrl;

`ifdef MD_CTRL_MEXT_EN
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CW-1:0] MUL_L = CW'(MUL_LATENCY);
  localparam logic [CW-1:0] DIV_L = CW'(DIV_LATENCY);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          md_e;
  logic [CW-1:0] lat_e;

  assign md_e  = (ctrl_e_q.alu_ctrl == ALU_MUL) || (ctrl_e_q.alu_ctrl == ALU_DIV) ||
                 (ctrl_e_q.alu_ctrl == ALU_REM);
  assign lat_e = (ctrl_e_q.alu_ctrl == ALU_MUL) ? MUL_L : DIV_L;

  // cnt holds the E cycles still to go after the current one
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_e) begin
          if (lat_e > ONE) begin
            md_stall = 1'b1;
            state_d  = BUSY;
            cnt_d    = lat_e - ONE;
          end else begin
            md_done = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d    = cnt_q - ONE;
        md_stall = (cnt_q > ONE);
        if (cnt_q <= ONE) begin
          md_done = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.FlushE) begin
      state_d = IDLE;
      cnt_d   = '0;
      md_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign md_stall = 1'b0;
  assign md_done  = 1'b0;
`endif

  assign bus.MdStall = md_stall;
  assign bus.MdDoneE = md_done;

endmodule

// File: tb/tb_md_ctrl_pipe.sv
// Directed bench for md_ctrl_pipe; M-extension scenarios run when MD_CTRL_MEXT_EN is defined.
module tb_md_ctrl_pipe;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_DIV = 32'h027342B3;
  localparam logic [31:0] I_REM = 32'h0273E2B3;
  localparam logic [31:0] I_MUL = 32'h027302B3;
  localparam logic [31:0] I_NOP = 32'h00000013;
  localparam logic [31:0] I_ILL = 32'h0000007F;
  localparam logic [31:0] I_BADR = 32'h402091B3;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  md_ctrl_pipe_if bus();

  md_ctrl_pipe #(.MUL_LATENCY(1), .DIV_LATENCY(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [10:0] e_word;
  assign e_word = {bus.RegWriteE, bus.MemWriteE, bus.ALUSrcE, bus.BranchE, bus.JumpE,
                   bus.ResultSrcE, bus.ALUControlE};

  function automatic logic [10:0] mkw(input logic rw, input logic mw, input logic as,
                                      input logic br, input logic j, input logic [1:0] rs,
                                      input logic [3:0] alu);
    return {rw, mw, as, br, j, rs, alu};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.FlushE = 1'b0;
    bus.InstrD = I_ILL;
    #2;
    tests++; if (bus.IllegalD !== 1'b1) begin fails++; $display("FAIL reset_illegal got %b want 1", bus.IllegalD); end
    tests++; if (e_word !== 11'd0) begin fails++; $display("FAIL reset_eword got %h want 0", e_word); end
    tests++; if ({bus.MdStall, bus.MdDoneE} !== 2'b00) begin fails++; $display("FAIL reset_md got %b want 00", {bus.MdStall, bus.MdDoneE}); end
    bus.InstrD = I_ADD;
    #1;
    tests++; if (bus.IllegalD !== 1'b0) begin fails++; $display("FAIL reset_legal got %b want 0", bus.IllegalD); end
    step();
    tests++; if (e_word !== 11'd0) begin fails++; $display("FAIL reset_held_eword got %h want 0", e_word); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    bus.InstrD = I_ADD;
    step();
    tests++; if (bus.RegWriteE !== 1'b1) begin fails++; $display("FAIL add_regwrite got %b want 1", bus.RegWriteE); end
    tests++; if (bus.ALUSrcE !== 1'b0) begin fails++; $display("FAIL add_alusrc got %b want 0", bus.ALUSrcE); end
    tests++; if (bus.ALUControlE !== 4'b0000) begin fails++; $display("FAIL add_aluctrl got %b want 0000", bus.ALUControlE); end
    tests++; if (bus.MdStall !== 1'b0) begin fails++; $display("FAIL add_stall got %b want 0", bus.MdStall); end
  endtask

  task automatic test_decode();
    logic [31:0] ins [12];
    logic [2:0]  imm [12];
    logic [10:0] wrd [12];
    ins[0]  = 32'h0000A183; imm[0]  = 3'b000; wrd[0]  = mkw(1, 0, 1, 0, 0, 2'b01, 4'b0000); // lw
    ins[1]  = 32'h0030A023; imm[1]  = 3'b001; wrd[1]  = mkw(0, 1, 1, 0, 0, 2'b00, 4'b0000); // sw
    ins[2]  = 32'h00208463; imm[2]  = 3'b010; wrd[2]  = mkw(0, 0, 0, 1, 0, 2'b00, 4'b0001); // beq
    ins[3]  = 32'h008000EF; imm[3]  = 3'b011; wrd[3]  = mkw(1, 0, 0, 0, 1, 2'b10, 4'b0000); // jal
    ins[4]  = 32'h123450B7; imm[4]  = 3'b100; wrd[4]  = mkw(1, 0, 1, 0, 0, 2'b00, 4'b0000); // lui
    ins[5]  = 32'h402081B3; imm[5]  = 3'b000; wrd[5]  = mkw(1, 0, 0, 0, 0, 2'b00, 4'b0001); // sub
    ins[6]  = 32'h4020D1B3; imm[6]  = 3'b000; wrd[6]  = mkw(1, 0, 0, 0, 0, 2'b00, 4'b0110); // sra
    ins[7]  = 32'h0020F1B3; imm[7]  = 3'b000; wrd[7]  = mkw(1, 0, 0, 0, 0, 2'b00, 4'b1000); // and
    ins[8]  = 32'h0020B1B3; imm[8]  = 3'b000; wrd[8]  = mkw(1, 0, 0, 0, 0, 2'b00, 4'b1100); // sltu
    ins[9]  = 32'h00508193; imm[9]  = 3'b000; wrd[9]  = mkw(1, 0, 1, 0, 0, 2'b00, 4'b0000); // addi
    ins[10] = 32'h0050C193; imm[10] = 3'b000; wrd[10] = mkw(1, 0, 1, 0, 0, 2'b00, 4'b1010); // xori
    ins[11] = 32'h4030D193; imm[11] = 3'b000; wrd[11] = mkw(1, 0, 1, 0, 0, 2'b00, 4'b0110); // srai
    for (int i = 0; i < 12; i++) begin
      bus.InstrD = ins[i];
      #1;
      tests++; if (bus.ImmSrcD !== imm[i]) begin fails++; $display("FAIL dec_imm[%0d] got %b want %b", i, bus.ImmSrcD, imm[i]); end
      tests++; if (bus.IllegalD !== 1'b0) begin fails++; $display("FAIL dec_illegal[%0d] got %b want 0", i, bus.IllegalD); end
      step();
      tests++; if (e_word !== wrd[i]) begin fails++; $display("FAIL dec_eword[%0d] got %b want %b", i, e_word, wrd[i]); end
    end
  endtask

  task automatic test_illegal();
    bus.InstrD = I_ILL;
    #1;
    tests++; if (bus.IllegalD !== 1'b1) begin fails++; $display("FAIL ill_opcode got %b want 1", bus.IllegalD); end
    step();
    tests++; if (e_word !== 11'd0) begin fails++; $display("FAIL ill_opcode_eword got %h want 0", e_word); end
    bus.InstrD = I_BADR;
    #1;
    tests++; if (bus.IllegalD !== 1'b1) begin fails++; $display("FAIL ill_funct got %b want 1", bus.IllegalD); end
    step();
    tests++; if (e_word !== 11'd0) begin fails++; $display("FAIL ill_funct_eword got %h want 0", e_word); end
    bus.InstrD = I_NOP;
    step();
  endtask

`ifdef MD_CTRL_MEXT_EN
  task automatic test_div();
    bus.InstrD = I_DIV;
    step();
    bus.InstrD = I_NOP;
    for (int k = 1; k <= 8; k++) begin
      tests++; if (bus.ALUControlE !== 4'b0011) begin fails++; $display("FAIL div_alu c%0d got %b want 0011", k, bus.ALUControlE); end
      tests++; if (bus.MdStall !== (k < 8)) begin fails++; $display("FAIL div_stall c%0d got %b want %b", k, bus.MdStall, (k < 8)); end
      tests++; if (bus.MdDoneE !== (k == 8)) begin fails++; $display("FAIL div_done c%0d got %b want %b", k, bus.MdDoneE, (k == 8)); end
      step();
    end
    tests++; if (e_word !== mkw(1, 0, 1, 0, 0, 2'b00, 4'b0000)) begin fails++; $display("FAIL div_next got %b want nop", e_word); end
    tests++; if (bus.MdStall !== 1'b0) begin fails++; $display("FAIL div_next_stall got %b want 0", bus.MdStall); end
  endtask

  task automatic test_reset_mid_div();
    bus.InstrD = I_DIV;
    step();
    step();
    step();
    bus.InstrD = I_NOP;
    tests++; if (bus.MdStall !== 1'b1) begin fails++; $display("FAIL rstdiv_pre_stall got %b want 1", bus.MdStall); end
    rst_n = 1'b0;
    #1;
    tests++; if (e_word !== 11'd0) begin fails++; $display("FAIL rstdiv_eword got %h want 0", e_word); end
    tests++; if ({bus.MdStall, bus.MdDoneE} !== 2'b00) begin fails++; $display("FAIL rstdiv_md got %b want 00", {bus.MdStall, bus.MdDoneE}); end
    #2;
    rst_n = 1'b1;
    step();
    tests++; if (e_word !== mkw(1, 0, 1, 0, 0, 2'b00, 4'b0000)) begin fails++; $display("FAIL rstdiv_after got %b want nop", e_word); end
    tests++; if (bus.MdStall !== 1'b0) begin fails++; $display("FAIL rstdiv_after_stall got %b want 0", bus.MdStall); end
  endtask

  task automatic test_flush_div();
    bus.InstrD = I_DIV;
    step();
    bus.InstrD = I_NOP;
    step();
    step();
    step();
    bus.FlushE = 1'b1;
    #1;
    tests++; if (bus.MdDoneE !== 1'b0) begin fails++; $display("FAIL flush_c4_done got %b want 0", bus.MdDoneE); end
    step();
    bus.FlushE = 1'b0;
    tests++; if (e_word !== 11'd0) begin fails++; $display("FAIL flush_eword got %h want 0", e_word); end
    tests++; if ({bus.MdStall, bus.MdDoneE} !== 2'b00) begin fails++; $display("FAIL flush_md got %b want 00", {bus.MdStall, bus.MdDoneE}); end
    step();
    tests++; if (e_word !== mkw(1, 0, 1, 0, 0, 2'b00, 4'b0000)) begin fails++; $display("FAIL flush_next got %b want nop", e_word); end
    tests++; if ({bus.MdStall, bus.MdDoneE} !== 2'b00) begin fails++; $display("FAIL flush_next_md got %b want 00", {bus.MdStall, bus.MdDoneE}); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    logic [3:0] exp_alu;
    bus.InstrD = I_DIV;
    step();
    bus.InstrD = I_REM;
    for (int k = 1; k <= 16; k++) begin
      exp_alu = (k <= 8) ? 4'b0011 : 4'b1011;
      tests++; if (bus.ALUControlE !== exp_alu) begin fails++; $display("FAIL b2b_alu c%0d got %b want %b", k, bus.ALUControlE, exp_alu); end
      tests++; if (bus.MdStall !== (k % 8 != 0)) begin fails++; $display("FAIL b2b_stall c%0d got %b want %b", k, bus.MdStall, (k % 8 != 0)); end
      if (bus.MdDoneE === 1'b1) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 9) bus.InstrD = I_NOP;
      step();
    end
    tests++; if (d1 !== 8) begin fails++; $display("FAIL b2b_first_done got %0d want 8", d1); end
    tests++; if (d2 - d1 !== 8) begin fails++; $display("FAIL b2b_done_gap got %0d want 8", d2 - d1); end
    tests++; if (bus.ALUControlE !== 4'b0000) begin fails++; $display("FAIL b2b_tail_alu got %b want 0000", bus.ALUControlE); end
  endtask

  task automatic test_mul();
    bus.InstrD = I_MUL;
    step();
    bus.InstrD = I_NOP;
    tests++; if (bus.ALUControlE !== 4'b0010) begin fails++; $display("FAIL mul_alu got %b want 0010", bus.ALUControlE); end
    tests++; if (bus.MdStall !== 1'b0) begin fails++; $display("FAIL mul_stall got %b want 0", bus.MdStall); end
    tests++; if (bus.MdDoneE !== 1'b1) begin fails++; $display("FAIL mul_done got %b want 1", bus.MdDoneE); end
    step();
    tests++; if (bus.MdDoneE !== 1'b0) begin fails++; $display("FAIL mul_done_after got %b want 0", bus.MdDoneE); end
    tests++; if (bus.ALUControlE !== 4'b0000) begin fails++; $display("FAIL mul_next_alu got %b want 0000", bus.ALUControlE); end
  endtask
`else
  task automatic test_no_mext();
    bus.InstrD = I_DIV;
    #1;
    tests++; if (bus.IllegalD !== 1'b1) begin fails++; $display("FAIL nomext_div_illegal got %b want 1", bus.IllegalD); end
    step();
    tests++; if (e_word !== 11'd0) begin fails++; $display("FAIL nomext_div_eword got %h want 0", e_word); end
    tests++; if (bus.MdStall !== 1'b0) begin fails++; $display("FAIL nomext_div_stall got %b want 0", bus.MdStall); end
    bus.InstrD = I_MUL;
    #1;
    tests++; if (bus.IllegalD !== 1'b1) begin fails++; $display("FAIL nomext_mul_illegal got %b want 1", bus.IllegalD); end
    step();
    tests++; if ({bus.MdStall, bus.MdDoneE} !== 2'b00) begin fails++; $display("FAIL nomext_mul_md got %b want 00", {bus.MdStall, bus.MdDoneE}); end
    bus.InstrD = I_NOP;
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_illegal();
`ifdef MD_CTRL_MEXT_EN
    test_div();
    test_reset_mid_div();
    test_flush_div();
    test_back_to_back();
    test_mul();
`else
    test_no_mext();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
